// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory write port.
// Holds the CPU in reset until a checksum-verified image is in IM.
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       mem_byte_addr,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, CHECK, DONE, ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t      state;
  logic [15:0] count;
  logic [23:0] word;
  logic [7:0]  xsum;
  logic [1:0]  byte_idx;

  logic        xfer;
  logic [15:0] hdr;
  logic [ADDR_W:0] wnext;
  logic [31:0] waddr_b;

  // Ready is a pure function of state so the source sees no comb path.
  assign byte_ready = (state == HDR_HI) || (state == HDR_LO) ||
                      (state == DATA)   || (state == CHECK);

  assign xfer  = byte_valid & byte_ready;
  assign hdr   = {count[15:8], byte_data};
  assign wnext = words_written + 1'b1;
  assign waddr_b = BASE_ADDR +
    {{(30-ADDR_W){1'b0}}, words_written[ADDR_W-1:0], 2'b00};

  // Loader FSM with all outputs registered; mem_we is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      word          <= '0;
      xsum          <= '0;
      byte_idx      <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_byte_addr <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= HDR_HI;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            xsum          <= '0;
            byte_idx      <= '0;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            count[15:8] <= byte_data;
            state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            count[7:0] <= byte_data;
            if (hdr == 16'h0) begin
              state <= CHECK;
            end else if ({1'b0, hdr} > CAP) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            word     <= {word[15:0], byte_data};
            xsum     <= xsum ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we        <= 1'b1;
              mem_addr      <= words_written[ADDR_W-1:0];
              mem_wdata     <= {word, byte_data};
              mem_byte_addr <= waddr_b;
              words_written <= wnext;
              if (32'(wnext) == 32'(count))
                state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (xfer) begin
            if (byte_data == xsum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
